pe_row_conv: RTL and testbench
==============================

// Module: pe_row_conv
// PURPOSE
//  Eyeriss-style processing element: computes one 1-D convolution row (filter row * ifmap row).
//  Holds weights, activations and partial sums in local scratchpads.
//  After computing, it systolically adds its psums to a psum stream arriving from the neighbouring PE.
//  Sits in the PE array under cluster control, which sequences load/start/sums.
// PARAMETERS
//  interfaceSize  64  reserved bus width for array integration; no effect on this block
//  dataSize       8   weight/activation width (signed two's complement)
//  wSpadNReg      16  weight scratchpad depth
//  aSpadNReg      16  activation scratchpad depth; psum scratchpad depth = aSpadNReg
//  derived: multResSize = 2*dataSize; macResSize = multResSize+4 (psum width, 20 by default)
// PORTS
//  clk          in   1           clock
//  nrst         in   1           asynchronous active-low reset
//  weights_i    in   dataSize    serial weight input
//  acts_i       in   dataSize    serial activation input
//  psum_i       in   macResSize  psum from upstream PE
//  psum_o       out  macResSize  registered psum to downstream PE
//  ctrl_loadw   in   1           weight load enable
//  ctrl_loada   in   1           activation load enable
//  ctrl_acount  in   8           number of valid activations (A)
//  ctrl_wcount  in   8           number of valid weights (W)
//  ctrl_start   in   1           start-compute pulse
//  flag_done    out  1           compute finished (level)
//  ctrl_sums    in   1           psum accumulate/shift enable
// BEHAVIOUR
//  One clock, posedge; nrst asynchronous active-low. Reset: psum_o=0, flag_done=0, all pointers 0, FSM IDLE.
//  Spad contents need not be cleared by reset.
//  Weight load: each edge with ctrl_loadw=1 writes weights_i to wspad[wptr], then wptr++.
//  Weight load: wptr returns to 0 on any edge with ctrl_loadw=0; writes past wSpadNReg-1 are dropped.
//  Activation load: same rules with ctrl_loada/acts_i/aptr/aSpadNReg.
//  Loads are accepted only in IDLE or DONE; a load clears flag_done and returns FSM to IDLE.
//  Effective counts: A = min(ctrl_acount, aSpadNReg); W = min(ctrl_wcount, wSpadNReg).
//  Number of outputs: N = A-W+1 if 1<=W<=A, else N=0.
//  FSM IDLE/DONE --ctrl_start--> COMPUTE; ctrl_start is ignored in COMPUTE and while any load is high.
//  COMPUTE does one signed MAC per cycle: out[j] = sum_{k=0..W-1} w[k]*a[j+k], for j = 0..N-1.
//  Product: multResSize bits, sign-extended; accumulation in macResSize bits, wrapping modulo 2^macResSize.
//  Each out[j] is written to pspad[j] after its W-th MAC.
//  COMPUTE lasts N*W cycles; after the final write the FSM enters DONE, where flag_done=1.
//  flag_done stays 1 until the next start or load.
//  If N=0, start goes straight to DONE on the next edge.
//  Psum chain: each edge with ctrl_sums=1 does psum_o <= psum_i + (sidx<N ? pspad[sidx] : 0), then sidx++ (wrap-safe).
//  sidx resets to 0 on any edge with ctrl_sums=0; psum_o holds its value while ctrl_sums=0.
//  Latency from psum_i to psum_o is one clock.
//  ctrl_sums during COMPUTE uses current pspad contents; the caller must not do this.
//  Reset asserted mid-operation aborts immediately to the reset state.
// TESTING
//  1 Reset: hold nrst=0 for 5 cycles -> psum_o=0, flag_done=0.
//  2 Load w={1,2,3} (W=3) and a={0..15} (A=16), pulse start -> flag_done=1 after 42 cycles, 14 outputs.
//  3 Then ctrl_sums=1, psum_i=1 -> psum_o after k-th edge = 6k+9 (9,15,...,87) for k=0..13.
//  4 Case 3 continued past k=13 -> psum_o=psum_i=1.
//  5 W=0 or W>A, pulse start -> flag_done=1 next cycle; sums give psum_o=psum_i.
//  6 Signed: w={-128}, a={127}, W=A=1 -> out=-16256; with psum_i=0, psum_o=20'hFC080.
//  7 Load during DONE -> flag_done drops; start during COMPUTE is ignored (done time unchanged).

Source files
------------

// File: rtl/pe_row_conv.sv
// pe_row_conv: processing element for one 1-D convolution row (filter row * ifmap row).
// Weights, activations and partial sums live in local scratchpads. After a compute pass the
// psums are added, one per cycle, to a psum stream coming from the neighbouring PE.
//
// Ports:
//   clk, nrst     clock, asynchronous active-low reset
//   weights_i     serial weight input (signed, dataSize)
//   acts_i        serial activation input (signed, dataSize)
//   psum_i        psum from upstream PE (macResSize)
//   psum_o        registered psum to downstream PE (macResSize)
//   ctrl_loadw    weight load enable
//   ctrl_loada    activation load enable
//   ctrl_acount   number of valid activations
//   ctrl_wcount   number of valid weights
//   ctrl_start    start-compute pulse
//   flag_done     compute finished (level)
//   ctrl_sums     psum accumulate/shift enable
module pe_row_conv #(
  parameter int unsigned interfaceSize = 64,
  parameter int unsigned dataSize      = 8,
  parameter int unsigned wSpadNReg     = 16,
  parameter int unsigned aSpadNReg     = 16,
  localparam int unsigned multResSize  = 2 * dataSize,
  localparam int unsigned macResSize   = multResSize + 4
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [dataSize-1:0]   weights_i,
  input  logic [dataSize-1:0]   acts_i,
  input  logic [macResSize-1:0] psum_i,
  output logic [macResSize-1:0] psum_o,
  input  logic                  ctrl_loadw,
  input  logic                  ctrl_loada,
  input  logic [7:0]            ctrl_acount,
  input  logic [7:0]            ctrl_wcount,
  input  logic                  ctrl_start,
  output logic                  flag_done,
  input  logic                  ctrl_sums
);

  // interfaceSize is reserved for array integration and does not shape this block.
  localparam int unsigned CntW  = 8 + 0 * interfaceSize;
  localparam int unsigned WIdxW = $clog2(wSpadNReg);
  localparam int unsigned AIdxW = $clog2(aSpadNReg);
  localparam int unsigned WPtrW = WIdxW + 1;
  localparam int unsigned APtrW = AIdxW + 1;

  localparam logic [WPtrW-1:0] WPtrMax = WPtrW'(wSpadNReg);
  localparam logic [APtrW-1:0] APtrMax = APtrW'(aSpadNReg);
  localparam logic [CntW-1:0]  WMax    = CntW'(wSpadNReg);
  localparam logic [CntW-1:0]  AMax    = CntW'(aSpadNReg);
  localparam logic [CntW-1:0]  One     = CntW'(1);

  typedef enum logic [1:0] {StIdle, StCompute, StDone} state_e;

  // Scratchpads: not reset, contents are only meaningful after a load/compute.
  logic signed [dataSize-1:0] wspad_q [wSpadNReg];
  logic signed [dataSize-1:0] aspad_q [aSpadNReg];
  logic [macResSize-1:0]      pspad_q [aSpadNReg];

  state_e                state_q, state_d;
  logic [WPtrW-1:0]      wptr_q, wptr_d;
  logic [APtrW-1:0]      aptr_q, aptr_d;
  logic [CntW-1:0]       wcnt_q, wcnt_d;
  logic [CntW-1:0]       nout_q, nout_d;
  logic [CntW-1:0]       j_q, j_d;
  logic [CntW-1:0]       k_q, k_d;
  logic [CntW-1:0]       sidx_q, sidx_d;
  logic [macResSize-1:0] acc_q, acc_d;
  logic [macResSize-1:0] psum_q, psum_d;

  logic                          load_ok, wspad_we, aspad_we, pspad_we;
  logic [CntW-1:0]               a_eff, w_eff, n_eff;
  logic [AIdxW-1:0]              a_idx;
  logic signed [dataSize-1:0]    w_cur, a_cur;
  logic signed [multResSize-1:0] prod;
  logic signed [macResSize-1:0]  prod_ext;
  logic [macResSize-1:0]         acc_sum, psum_add;

  assign load_ok  = (state_q != StCompute);
  assign wspad_we = ctrl_loadw && load_ok && (wptr_q < WPtrMax);
  assign aspad_we = ctrl_loada && load_ok && (aptr_q < APtrMax);

  assign a_eff = (ctrl_acount > AMax) ? AMax : ctrl_acount;
  assign w_eff = (ctrl_wcount > WMax) ? WMax : ctrl_wcount;
  assign n_eff = ((w_eff != '0) && (w_eff <= a_eff)) ? (a_eff - w_eff + One) : '0;

  // MAC datapath: out[j] accumulates w[k]*a[j+k]; accumulator restarts at k == 0.
  assign a_idx    = AIdxW'(j_q + k_q);
  assign w_cur    = wspad_q[k_q[WIdxW-1:0]];
  assign a_cur    = aspad_q[a_idx];
  assign prod     = multResSize'(w_cur) * multResSize'(a_cur);
  assign prod_ext = macResSize'(prod);
  assign acc_sum  = ((k_q == '0) ? '0 : acc_q) + prod_ext;

  assign psum_add = (sidx_q < nout_q) ? pspad_q[sidx_q[AIdxW-1:0]] : '0;

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    nout_d   = nout_q;
    j_d      = j_q;
    k_d      = k_q;
    acc_d    = acc_q;
    pspad_we = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (ctrl_loadw || ctrl_loada) begin
          state_d = StIdle;
        end else if (ctrl_start) begin
          wcnt_d  = w_eff;
          nout_d  = n_eff;
          j_d     = '0;
          k_d     = '0;
          state_d = (n_eff == '0) ? StDone : StCompute;
        end
      end
      StCompute: begin
        acc_d = acc_sum;
        if (k_q == wcnt_q - One) begin
          pspad_we = 1'b1;
          k_d      = '0;
          if (j_q == nout_q - One) begin
            state_d = StDone;
          end else begin
            j_d = j_q + One;
          end
        end else begin
          k_d = k_q + One;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Load pointers: advance while loading (saturating at depth), rewind when the load drops.
  always_comb begin
    wptr_d = wptr_q;
    aptr_d = aptr_q;
    if (!ctrl_loadw) begin
      wptr_d = '0;
    end else if (wspad_we) begin
      wptr_d = wptr_q + WPtrW'(1);
    end
    if (!ctrl_loada) begin
      aptr_d = '0;
    end else if (aspad_we) begin
      aptr_d = aptr_q + APtrW'(1);
    end
  end

  // Psum chain: stream stored outputs onto the incoming psums; sidx saturates instead of wrapping.
  always_comb begin
    psum_d = psum_q;
    sidx_d = '0;
    if (ctrl_sums) begin
      psum_d = psum_i + psum_add;
      sidx_d = (sidx_q == '1) ? sidx_q : sidx_q + One;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= StIdle;
      wptr_q  <= '0;
      aptr_q  <= '0;
      wcnt_q  <= '0;
      nout_q  <= '0;
      j_q     <= '0;
      k_q     <= '0;
      sidx_q  <= '0;
      acc_q   <= '0;
      psum_q  <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      aptr_q  <= aptr_d;
      wcnt_q  <= wcnt_d;
      nout_q  <= nout_d;
      j_q     <= j_d;
      k_q     <= k_d;
      sidx_q  <= sidx_d;
      acc_q   <= acc_d;
      psum_q  <= psum_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wspad_we) wspad_q[wptr_q[WIdxW-1:0]] <= weights_i;
    if (aspad_we) aspad_q[aptr_q[AIdxW-1:0]] <= acts_i;
    if (pspad_we) pspad_q[j_q[AIdxW-1:0]] <= acc_sum;
  end

  assign psum_o    = psum_q;
  assign flag_done = (state_q == StDone);

endmodule

// File: tb/tb_pe_row_conv.sv
// Directed bench for pe_row_conv: reset, 1-D convolution, psum chain, degenerate counts,
// signed extremes, load/start interactions and mid-operation reset.
module tb_pe_row_conv;

  logic        clk;
  logic        nrst;
  logic [7:0]  weights_i;
  logic [7:0]  acts_i;
  logic [19:0] psum_i;
  logic [19:0] psum_o;
  logic        ctrl_loadw;
  logic        ctrl_loada;
  logic [7:0]  ctrl_acount;
  logic [7:0]  ctrl_wcount;
  logic        ctrl_start;
  logic        flag_done;
  logic        ctrl_sums;

  int n_pass;
  int n_total;
  int cycles;

  pe_row_conv dut (
    .clk        (clk),
    .nrst       (nrst),
    .weights_i  (weights_i),
    .acts_i     (acts_i),
    .psum_i     (psum_i),
    .psum_o     (psum_o),
    .ctrl_loadw (ctrl_loadw),
    .ctrl_loada (ctrl_loada),
    .ctrl_acount(ctrl_acount),
    .ctrl_wcount(ctrl_wcount),
    .ctrl_start (ctrl_start),
    .flag_done  (flag_done),
    .ctrl_sums  (ctrl_sums)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_w(input logic [7:0] v);
    weights_i  = v;
    ctrl_loadw = 1'b1;
    tick();
    ctrl_loadw = 1'b0;
  endtask

  task automatic pulse_start();
    ctrl_start = 1'b1;
    tick();
    ctrl_start = 1'b0;
  endtask

  // Counts edges after the start edge until flag_done rises (bounded).
  task automatic wait_done(input int restart_at, output int n);
    n = 0;
    while (!flag_done && n < 200) begin
      ctrl_start = (n == restart_at);
      tick();
      n++;
    end
    ctrl_start = 1'b0;
  endtask

  initial begin
    n_pass      = 0;
    n_total     = 0;
    nrst        = 1'b0;
    weights_i   = '0;
    acts_i      = '0;
    psum_i      = '0;
    ctrl_loadw  = 1'b0;
    ctrl_loada  = 1'b0;
    ctrl_acount = '0;
    ctrl_wcount = '0;
    ctrl_start  = 1'b0;
    ctrl_sums   = 1'b0;

    // Reset held for 5 cycles.
    repeat (5) tick();
    check("reset_psum", 32'(psum_o), 32'h0);
    check("reset_done", 32'(flag_done), 32'h0);
    nrst = 1'b1;
    tick();

    // w = {1,2,3}, a = {0..15}: 14 outputs, 42 compute cycles.
    ctrl_wcount = 8'd3;
    ctrl_acount = 8'd16;
    for (int i = 1; i <= 3; i++) begin
      weights_i  = 8'(i);
      ctrl_loadw = 1'b1;
      tick();
    end
    ctrl_loadw = 1'b0;
    for (int i = 0; i < 16; i++) begin
      acts_i     = 8'(i);
      ctrl_loada = 1'b1;
      tick();
    end
    ctrl_loada = 1'b0;
    tick();
    pulse_start();
    check("busy_after_start", 32'(flag_done), 32'h0);
    wait_done(-1, cycles);
    check("conv_cycles", 32'(cycles), 32'd42);
    check("conv_done", 32'(flag_done), 32'h1);

    // Restart from DONE; a second start mid-compute must not change timing.
    pulse_start();
    check("restart_clears_done", 32'(flag_done), 32'h0);
    wait_done(5, cycles);
    check("start_in_compute_ignored", 32'(cycles), 32'd42);

    // Psum chain: psum_o after k-th edge = 6k+9, then passthrough.
    ctrl_sums = 1'b1;
    psum_i    = 20'd1;
    for (int k = 0; k < 14; k++) begin
      tick();
      check($sformatf("chain_k%0d", k), 32'(psum_o), 32'(6 * k + 9));
    end
    tick();
    check("chain_past_n", 32'(psum_o), 32'd1);
    tick();
    check("chain_past_n2", 32'(psum_o), 32'd1);
    ctrl_sums = 1'b0;
    psum_i    = 20'd5;
    tick();
    check("chain_hold", 32'(psum_o), 32'd1);

    // Load during DONE drops flag_done.
    load_w(8'd1);
    check("load_clears_done", 32'(flag_done), 32'h0);

    // W = 0: straight to DONE, sums pass psum_i through.
    ctrl_wcount = 8'd0;
    ctrl_acount = 8'd16;
    pulse_start();
    check("w0_done", 32'(flag_done), 32'h1);
    ctrl_sums = 1'b1;
    psum_i    = 20'd7;
    tick();
    check("w0_pass", 32'(psum_o), 32'd7);
    ctrl_sums = 1'b0;

    // W > A: same degenerate behaviour.
    load_w(8'd9);
    check("load_clears_done2", 32'(flag_done), 32'h0);
    ctrl_wcount = 8'd5;
    ctrl_acount = 8'd3;
    pulse_start();
    check("wgta_done", 32'(flag_done), 32'h1);
    ctrl_sums = 1'b1;
    psum_i    = 20'd3;
    tick();
    check("wgta_pass", 32'(psum_o), 32'd3);
    ctrl_sums = 1'b0;

    // Signed extremes: -128 * 127 = -16256 -> 20'hFC080.
    load_w(8'h80);
    acts_i     = 8'h7F;
    ctrl_loada = 1'b1;
    tick();
    ctrl_loada  = 1'b0;
    ctrl_wcount = 8'd1;
    ctrl_acount = 8'd1;
    pulse_start();
    wait_done(-1, cycles);
    check("signed_cycles", 32'(cycles), 32'd1);
    ctrl_sums = 1'b1;
    psum_i    = 20'd0;
    tick();
    check("signed_psum", 32'(psum_o), 32'hFC080);

    // Asynchronous reset mid-stream clears outputs immediately.
    nrst = 1'b0;
    #1;
    check("async_rst_psum", 32'(psum_o), 32'h0);
    check("async_rst_done", 32'(flag_done), 32'h0);
    ctrl_sums = 1'b0;
    tick();
    nrst = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
